// File: rtl/delay_sched_pkg.sv
// -----------------------------------------------------------------------------
// delay_sched_pkg
// Shared types and width derivations for the delay_scheduler timing wheel.
//
// The wheel slot struct is sized from the package defaults below. The
// delay_scheduler parameters default to the same values; when the scheduler is
// built with different DATA_WIDTH / NUM_REQ / MAX_DELAY values, the matching
// SCHED_* constants here must be changed with them so the slot fields line up.
// -----------------------------------------------------------------------------
package delay_sched_pkg;

   // Default configuration of the scheduler.
   localparam int unsigned SCHED_DATA_WIDTH = 8;
   localparam int unsigned SCHED_NUM_REQ    = 4;
   localparam int unsigned SCHED_MAX_DELAY  = 8;

   // Slot index into the wheel (MAX_DELAY is a power of two).
   localparam int unsigned SCHED_SLOT_W  = $clog2(SCHED_MAX_DELAY);
   // Delay field needs one extra bit so that MAX_DELAY itself is encodable.
   localparam int unsigned SCHED_DELAY_W = SCHED_SLOT_W + 1;
   // Requester index carried with every payload.
   localparam int unsigned SCHED_ID_W    = $clog2(SCHED_NUM_REQ);
   // Occupancy must reach MAX_DELAY (a completely full wheel).
   localparam int unsigned SCHED_OCC_W   = SCHED_SLOT_W + 1;

   // One wheel slot: payload plus the requester that produced it.
   typedef struct packed {
      logic                        valid;
      logic [SCHED_DATA_WIDTH-1:0] data;
      logic [SCHED_ID_W-1:0]       id;
   } wheel_slot_t;

endpackage : delay_sched_pkg

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Round-robin arbiter. The search starts at the pointer and the pointer moves
// to the index after the winner only when a grant is issued, so a requester
// that is skipped while ineligible keeps its place in the rotation.
//
// Ports
//   clk_i        clock, rising edge
//   rst_n_i      synchronous active-low reset (pointer back to 0)
//   req_i        request vector (already qualified by the caller)
//   grant_o      one-hot grant, combinational from req_i and the pointer
//   grant_idx_o  binary index of the granted requester (0 when none)
//   valid_o      a grant is issued this cycle
// -----------------------------------------------------------------------------
module rr_arbiter #(
   parameter int unsigned N = 4
) (
   input  logic                 clk_i,
   input  logic                 rst_n_i,
   input  logic [N-1:0]         req_i,
   output logic [N-1:0]         grant_o,
   output logic [$clog2(N)-1:0] grant_idx_o,
   output logic                 valid_o
);

   localparam int unsigned IW = $clog2(N);

   logic [IW-1:0] ptr_q;
   logic [IW-1:0] ptr_d;
   logic [N-1:0]  grant_s;
   logic [IW-1:0] idx_s;
   logic          found_s;
   logic [IW:0]   idx_inc_s;

   // Pick the first requester at or after the pointer, wrapping at N.
   always_comb begin
      grant_s = '0;
      idx_s   = '0;
      found_s = 1'b0;
      for (int off = 0; off < int'(N); off++) begin
         int  sum;
         int  cand;
         logic hit;
         sum  = int'(ptr_q) + off;
         cand = (sum >= int'(N)) ? (sum - int'(N)) : sum;
         hit  = ~found_s & req_i[cand];
         grant_s[cand] = grant_s[cand] | hit;
         idx_s   = hit ? IW'(cand) : idx_s;
         found_s = found_s | hit;
      end
   end

   // Next pointer: index after the winner on a grant, otherwise unchanged.
   always_comb begin
      idx_inc_s = {1'b0, idx_s} + {{IW{1'b0}}, 1'b1};
      if (found_s) begin
         ptr_d = (idx_inc_s == (IW + 1)'(N)) ? '0 : idx_inc_s[IW-1:0];
      end else begin
         ptr_d = ptr_q;
      end
   end

   // Pointer register.
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

   assign grant_o     = grant_s;
   assign grant_idx_o = idx_s;
   assign valid_o     = found_s;

endmodule : rr_arbiter

// File: rtl/delay_scheduler.sv
// -----------------------------------------------------------------------------
// delay_scheduler
// Timing-wheel scheduler. Each cycle one requester may deposit a payload that
// re-emerges a requested number of ticks later. The wheel has MAX_DELAY slots;
// the "now" pointer advances every cycle and the slot under it is drained into
// the registered output and cleared.
//
// Ports
//   clk          clock, rising edge
//   rst_n        synchronous active-low reset
//   req_valid    per-requester request
//   req_data     per-requester payload, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_delay    per-requester delay, requester i at [i*DW +: DW], DW=$clog2(MAX_DELAY)+1
//   req_ready    one-hot grant (combinational)
//   out_valid    payload emitted this cycle (registered)
//   out_data     emitted payload, holds when nothing is emitted
//   out_id       requester index of the emitted payload, holds likewise
//   occupancy    number of valid wheel slots (registered)
//   stat_accepted / stat_blocked  16-bit saturating counters, present only
//                when DELAY_SCHED_STATS_EN is defined
//
// Optional feature macro: DELAY_SCHED_STATS_EN
// -----------------------------------------------------------------------------
module delay_scheduler
   import delay_sched_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = SCHED_DATA_WIDTH,
   parameter int unsigned NUM_REQ    = SCHED_NUM_REQ,
   parameter int unsigned MAX_DELAY  = SCHED_MAX_DELAY
) (
   input  logic                                         clk,
   input  logic                                         rst_n,
   input  logic [NUM_REQ-1:0]                           req_valid,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]                req_data,
   input  logic [NUM_REQ*($clog2(MAX_DELAY)+1)-1:0]     req_delay,
   output logic [NUM_REQ-1:0]                           req_ready,
   output logic                                         out_valid,
   output logic [DATA_WIDTH-1:0]                        out_data,
   output logic [$clog2(NUM_REQ)-1:0]                   out_id,
`ifdef DELAY_SCHED_STATS_EN
   output logic [15:0]                                  stat_accepted,
   output logic [15:0]                                  stat_blocked,
`endif
   output logic [$clog2(MAX_DELAY):0]                   occupancy
);

   localparam int unsigned SLOT_W  = $clog2(MAX_DELAY);
   localparam int unsigned DELAY_W = SLOT_W + 1;
   localparam int unsigned ID_W    = $clog2(NUM_REQ);
   localparam int unsigned OCC_W   = SLOT_W + 1;
   localparam logic [DELAY_W-1:0] MAX_DLY_V = DELAY_W'(MAX_DELAY);

   // Wheel state and registered outputs.
   wheel_slot_t           wheel_q [MAX_DELAY];
   wheel_slot_t           wheel_d [MAX_DELAY];
   logic [SLOT_W-1:0]     now_q;
   logic [SLOT_W-1:0]     now_d;
   logic                  out_valid_q;
   logic                  out_valid_d;
   logic [DATA_WIDTH-1:0] out_data_q;
   logic [DATA_WIDTH-1:0] out_data_d;
   logic [ID_W-1:0]       out_id_q;
   logic [ID_W-1:0]       out_id_d;
   logic [OCC_W-1:0]      occ_q;
   logic [OCC_W-1:0]      occ_d;

   // Per-requester qualification.
   logic [SLOT_W-1:0]     target_s [NUM_REQ];
   logic [NUM_REQ-1:0]    legal_s;
   logic [NUM_REQ-1:0]    occupied_s;
   logic [NUM_REQ-1:0]    eligible_s;

   // Arbiter result and the selected write.
   logic [NUM_REQ-1:0]    grant_s;
   logic [ID_W-1:0]       gnt_idx_s;
   logic                  gnt_any_s;
   logic [SLOT_W-1:0]     gnt_target_s;
   logic [DATA_WIDTH-1:0] gnt_data_s;
   wheel_slot_t           drain_s;

   // Legality, target slot and eligibility of each requester. A target equal
   // to "now" is free because that slot is drained on the same edge.
   always_comb begin
      logic [DELAY_W-1:0] dly;
      dly        = '0;
      legal_s    = '0;
      occupied_s = '0;
      eligible_s = '0;
      for (int i = 0; i < int'(NUM_REQ); i++) begin
         dly           = req_delay[i*DELAY_W +: DELAY_W];
         legal_s[i]    = (dly != {DELAY_W{1'b0}}) && (dly <= MAX_DLY_V);
         target_s[i]   = now_q + dly[SLOT_W-1:0];
         occupied_s[i] = wheel_q[target_s[i]].valid && (target_s[i] != now_q);
         eligible_s[i] = rst_n & req_valid[i] & legal_s[i] & ~occupied_s[i];
      end
   end

   rr_arbiter #(
      .N (NUM_REQ)
   ) u_rr_arbiter (
      .clk_i       (clk),
      .rst_n_i     (rst_n),
      .req_i       (eligible_s),
      .grant_o     (grant_s),
      .grant_idx_o (gnt_idx_s),
      .valid_o     (gnt_any_s)
   );

   assign req_ready    = grant_s;
   assign gnt_target_s = target_s[gnt_idx_s];
   assign gnt_data_s   = req_data[gnt_idx_s*DATA_WIDTH +: DATA_WIDTH];

   // Wheel next state: clear the drained slot, then apply the grant write so a
   // full-length delay (target == now) overrides the clear.
   always_comb begin
      for (int s = 0; s < int'(MAX_DELAY); s++) begin
         wheel_d[s] = wheel_q[s];
      end
      drain_s = wheel_q[now_q];
      wheel_d[now_q].valid = 1'b0;
      if (gnt_any_s) begin
         wheel_d[gnt_target_s].valid = 1'b1;
         wheel_d[gnt_target_s].data  = gnt_data_s;
         wheel_d[gnt_target_s].id    = gnt_idx_s;
      end else begin
         wheel_d[now_q].valid = 1'b0;
      end
   end

   // Output, tick pointer and occupancy next state.
   always_comb begin
      now_d       = now_q + {{(SLOT_W-1){1'b0}}, 1'b1};
      out_valid_d = drain_s.valid;
      if (drain_s.valid) begin
         out_data_d = drain_s.data;
         out_id_d   = drain_s.id;
      end else begin
         out_data_d = out_data_q;
         out_id_d   = out_id_q;
      end
      case ({gnt_any_s, drain_s.valid})
         2'b10:   occ_d = occ_q + {{(OCC_W-1){1'b0}}, 1'b1};
         2'b01:   occ_d = occ_q - {{(OCC_W-1){1'b0}}, 1'b1};
         default: occ_d = occ_q;
      endcase
   end

   // State registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int s = 0; s < int'(MAX_DELAY); s++) begin
            wheel_q[s] <= '0;
         end
         now_q       <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_id_q    <= '0;
         occ_q       <= '0;
      end else begin
         for (int s = 0; s < int'(MAX_DELAY); s++) begin
            wheel_q[s] <= wheel_d[s];
         end
         now_q       <= now_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_id_q    <= out_id_d;
         occ_q       <= occ_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_id    = out_id_q;
   assign occupancy = occ_q;

`ifdef DELAY_SCHED_STATS_EN
   logic [15:0] acc_q;
   logic [15:0] acc_d;
   logic [15:0] blk_q;
   logic [15:0] blk_d;
   logic        blocked_s;

   // A cycle is "blocked" when some valid, legal request lost only because its
   // target slot was occupied.
   always_comb begin
      blocked_s = |(req_valid & legal_s & occupied_s);
      if (gnt_any_s && (acc_q != 16'hFFFF)) begin
         acc_d = acc_q + 16'd1;
      end else begin
         acc_d = acc_q;
      end
      if (blocked_s && (blk_q != 16'hFFFF)) begin
         blk_d = blk_q + 16'd1;
      end else begin
         blk_d = blk_q;
      end
   end

   // Statistics registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         acc_q <= 16'd0;
         blk_q <= 16'd0;
      end else begin
         acc_q <= acc_d;
         blk_q <= blk_d;
      end
   end

   assign stat_accepted = acc_q;
   assign stat_blocked  = blk_q;
`endif

endmodule : delay_scheduler

// File: tb/tb_delay_scheduler.sv
// -----------------------------------------------------------------------------
// tb_delay_scheduler
// Directed bench for delay_scheduler with the default configuration
// (DATA_WIDTH=8, NUM_REQ=4, MAX_DELAY=8). Each step states the expected
// req_ready; accepted payloads are pushed to a scoreboard with their emit edge
// and retired when the DUT emits them.
// -----------------------------------------------------------------------------
module tb_delay_scheduler;

   localparam int DW  = 8;
   localparam int NR  = 4;
   localparam int MD  = 8;
   localparam int DLW = 4;
   localparam int IW  = 2;
   localparam int OW  = 4;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [NR-1:0]     req_valid;
   logic [NR*DW-1:0]  req_data;
   logic [NR*DLW-1:0] req_delay;
   logic [NR-1:0]     req_ready;
   logic              out_valid;
   logic [DW-1:0]     out_data;
   logic [IW-1:0]     out_id;
   logic [OW-1:0]     occupancy;
`ifdef DELAY_SCHED_STATS_EN
   logic [15:0]       stat_accepted;
   logic [15:0]       stat_blocked;
`endif

   delay_scheduler #(
      .DATA_WIDTH (DW),
      .NUM_REQ    (NR),
      .MAX_DELAY  (MD)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .req_valid     (req_valid),
      .req_data      (req_data),
      .req_delay     (req_delay),
      .req_ready     (req_ready),
      .out_valid     (out_valid),
      .out_data      (out_data),
      .out_id        (out_id),
`ifdef DELAY_SCHED_STATS_EN
      .stat_accepted (stat_accepted),
      .stat_blocked  (stat_blocked),
`endif
      .occupancy     (occupancy)
   );

   always #5 clk = ~clk;

   typedef struct {
      int             emit;
      logic [DW-1:0]  data;
      logic [IW-1:0]  id;
   } exp_t;

   exp_t          sb_q[$];
   int            checks    = 0;
   int            errors    = 0;
   int            edge_cnt  = 0;
   int            exp_occ   = 0;
   int            exp_acc   = 0;
   int            exp_blk   = 0;
   logic [DW-1:0] last_data = '0;
   logic [IW-1:0] last_id   = '0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic set_req(input int i, input logic v, input logic [DW-1:0] d, input logic [DLW-1:0] dl);
      req_valid[i]              = v;
      req_data[i*DW +: DW]      = d;
      req_delay[i*DLW +: DLW]   = dl;
   endtask

   task automatic clear_reqs();
      req_valid = '0;
      req_data  = '0;
      req_delay = '0;
   endtask

   // One clock: check req_ready mid-cycle, record accepts, then check outputs
   // just after the rising edge.
   task automatic tick(input logic [NR-1:0] exp_rdy, input logic blk, input string tag);
      logic rst_at;
      int   n_acc;
      int   hit;
      logic exp_valid;
      exp_t e;
      @(negedge clk);
      rst_at = rst_n;
      chk({tag, " req_ready"}, 32'(req_ready), 32'(exp_rdy));
      n_acc = 0;
      for (int i = 0; i < NR; i++) begin
         if (rst_at && exp_rdy[i] && req_valid[i]) begin
            e.emit = edge_cnt + 1 + int'(req_delay[i*DLW +: DLW]);
            e.data = req_data[i*DW +: DW];
            e.id   = IW'(i);
            sb_q.push_back(e);
            n_acc++;
         end
      end
      @(posedge clk);
      edge_cnt++;
      #1;
      exp_valid = 1'b0;
      if (!rst_at) begin
         sb_q.delete();
         exp_occ   = 0;
         exp_acc   = 0;
         exp_blk   = 0;
         last_data = '0;
         last_id   = '0;
      end else begin
         hit = -1;
         foreach (sb_q[k]) begin
            if (hit < 0 && sb_q[k].emit == edge_cnt) hit = k;
         end
         if (hit >= 0) begin
            exp_valid = 1'b1;
            last_data = sb_q[hit].data;
            last_id   = sb_q[hit].id;
            sb_q.delete(hit);
         end
         exp_occ = exp_occ + n_acc - (exp_valid ? 1 : 0);
         exp_acc = exp_acc + n_acc;
         if (blk) exp_blk++;
      end
      chk({tag, " out_valid"}, 32'(out_valid), 32'(exp_valid));
      chk({tag, " out_data"},  32'(out_data),  32'(last_data));
      chk({tag, " out_id"},    32'(out_id),    32'(last_id));
      chk({tag, " occupancy"}, 32'(occupancy), 32'(exp_occ));
`ifdef DELAY_SCHED_STATS_EN
      chk({tag, " stat_accepted"}, 32'(stat_accepted), 32'(exp_acc));
      chk({tag, " stat_blocked"},  32'(stat_blocked),  32'(exp_blk));
`endif
   endtask

   initial begin
      rst_n = 1'b0;
      clear_reqs();
      tick(4'b0000, 1'b0, "reset1");
      tick(4'b0000, 1'b0, "reset2");
      rst_n = 1'b1;

      // Single requester, delay 1: accepted at edge 3, visible after edge 4.
      set_req(0, 1'b1, 8'hA5, 4'd1);
      tick(4'b0001, 1'b0, "d1_accept");
      clear_reqs();
      tick(4'b0000, 1'b0, "d1_emit");
      tick(4'b0000, 1'b0, "d1_hold");

      // A request held during reset is never granted.
      set_req(0, 1'b1, 8'h5A, 4'd1);
      rst_n = 1'b0;
      tick(4'b0000, 1'b0, "rst_ready");
      clear_reqs();
      rst_n = 1'b1;

      // Round robin from pointer 0: requester 1 then requester 2.
      set_req(1, 1'b1, 8'h11, 4'd3);
      set_req(2, 1'b1, 8'h22, 4'd5);
      tick(4'b0010, 1'b0, "rr_first");
      set_req(1, 1'b0, 8'h00, 4'd0);
      tick(4'b0100, 1'b0, "rr_second");
      clear_reqs();
      repeat (6) tick(4'b0000, 1'b0, "rr_drain");

      // Slot collision: requester 1 targets the slot requester 0 holds.
      set_req(0, 1'b1, 8'h33, 4'd4);
      tick(4'b0001, 1'b0, "col_first");
      set_req(0, 1'b0, 8'h00, 4'd0);
      set_req(1, 1'b1, 8'h44, 4'd3);
      set_req(2, 1'b1, 8'h55, 4'd2);
      tick(4'b0100, 1'b1, "col_block");
      set_req(2, 1'b0, 8'h00, 4'd0);
      tick(4'b0010, 1'b0, "col_retry");
      clear_reqs();
      repeat (4) tick(4'b0000, 1'b0, "col_drain");

      // Delay MAX_DELAY every cycle: fill the wheel, then write while draining.
      for (int k = 0; k < 9; k++) begin
         set_req(3, 1'b1, 8'h80 + 8'(k), 4'd8);
         tick(4'b1000, 1'b0, "full_wheel");
      end
      clear_reqs();
      repeat (8) tick(4'b0000, 1'b0, "full_drain");

      // Illegal delays 0 and 9 never granted, others still served.
      set_req(0, 1'b1, 8'hC0, 4'd0);
      set_req(1, 1'b1, 8'hC1, 4'd9);
      set_req(2, 1'b1, 8'h66, 4'd2);
      tick(4'b0100, 1'b0, "illegal_a");
      set_req(2, 1'b0, 8'h00, 4'd0);
      set_req(3, 1'b1, 8'h77, 4'd5);
      tick(4'b1000, 1'b0, "illegal_b");
      set_req(3, 1'b0, 8'h00, 4'd0);
      tick(4'b0000, 1'b0, "illegal_only");
      clear_reqs();
      repeat (4) tick(4'b0000, 1'b0, "illegal_drain");

      // Three pending payloads discarded by a mid-run reset.
      for (int k = 0; k < 3; k++) begin
         set_req(0, 1'b1, 8'h91 + 8'(k), 4'd6);
         tick(4'b0001, 1'b0, "pend_fill");
      end
      clear_reqs();
      rst_n = 1'b0;
      tick(4'b0000, 1'b0, "rst_mid");
      rst_n = 1'b1;
      repeat (8) tick(4'b0000, 1'b0, "post_rst");

      chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_delay_scheduler
